// File: rtl/alu_op_issuer.sv
// Initiator side of a 32-bit ALU operand/opcode interface: registers requests toward a
// combinational ALU and returns tagged results in order through a small response FIFO.
module alu_op_issuer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAGW  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [WIDTH-1:0]           req_a_i,
    input  logic [WIDTH-1:0]           req_b_i,
    input  logic [2:0]                 req_op_i,
    input  logic [TAGW-1:0]            req_tag_i,
    output logic [WIDTH-1:0]           alu_a_o,
    output logic [WIDTH-1:0]           alu_b_o,
    output logic [2:0]                 alu_opcode_o,
    input  logic [WIDTH-1:0]           alu_result_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [WIDTH-1:0]           rsp_result_o,
    output logic [TAGW-1:0]            rsp_tag_o,
    output logic                       rsp_err_o,
    output logic [$clog2(DEPTH):0]     inflight_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAGW-1:0]  tag;
        logic             err;
    } rsp_t;

    logic             stage_valid_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_op_q;
    logic [TAGW-1:0]  tag_q;
    logic             err_q;

    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic [CntW-1:0]  count_d;
    logic [CntW-1:0]  inflight_q;
    logic [CntW-1:0]  inflight_d;
    rsp_t             mem_q [DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic illegal;
    rsp_t push_entry;
    rsp_t head;

    // Ready depends only on registered occupancy, so a pop frees space one cycle later.
    assign req_ready_o = (inflight_q < CntW'(DEPTH));
    assign accept      = req_valid_i & req_ready_o;
    assign illegal     = (req_op_i > 3'd2);
    assign push        = stage_valid_q;
    assign pop         = rsp_valid_o & rsp_ready_i;

    assign push_entry.result = err_q ? '0 : alu_result_i;
    assign push_entry.tag    = tag_q;
    assign push_entry.err    = err_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
        inflight_d = count_d + CntW'(accept);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_valid_q <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            tag_q         <= '0;
            err_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= '0;
        end else begin
            stage_valid_q <= accept;
            if (accept) begin
                alu_a_q  <= req_a_i;
                alu_b_q  <= req_b_i;
                alu_op_q <= req_op_i;
                tag_q    <= req_tag_i;
                err_q    <= illegal;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign rsp_valid_o  = (count_q != '0);
    assign rsp_result_o = rsp_valid_o ? head.result : '0;
    assign rsp_tag_o    = rsp_valid_o ? head.tag : '0;
    assign rsp_err_o    = rsp_valid_o ? head.err : 1'b0;

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_opcode_o = alu_op_q;
    assign inflight_o   = inflight_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a queue-based model of in-order tagged responses.
module tb_alu_op_issuer;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [W-1:0]  req_a, req_b;
    logic [2:0]    req_op;
    logic [TW-1:0] req_tag;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic [2:0]    alu_opcode;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_result;
    logic [TW-1:0] rsp_tag;
    logic          rsp_err;
    logic [2:0]    inflight;

    always #5 clk = ~clk;

    alu_op_issuer #(.WIDTH(W), .TAGW(TW), .DEPTH(D)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_op_i     (req_op),
        .req_tag_i    (req_tag),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_opcode_o (alu_opcode),
        .alu_result_i (alu_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_tag_o    (rsp_tag),
        .rsp_err_o    (rsp_err),
        .inflight_o   (inflight)
    );

    // Behavioural ALU; illegal opcodes return junk that the issuer must mask.
    always_comb begin
        case (alu_opcode)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = alu_a ^ alu_b ^ 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic [W-1:0]  result;
        logic [TW-1:0] tag;
        logic          err;
        int unsigned   ready_edge;
    } exp_t;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [2:0]    op;
        logic [TW-1:0] tag;
        logic [W-1:0]  exp_res;
        logic          exp_err;
    } vec_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pop = 0;
    int unsigned edge_cnt = 0;
    logic [W-1:0] last_a = '0, last_b = '0;
    logic [2:0]   last_op = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) edge_cnt++;

    // Outputs are checked mid-cycle; the queue holds every accepted request in order,
    // each becoming visible two edges after the cycle it was offered in.
    always @(negedge clk) begin : mon
        bit hv;
        int sz;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            last_a  = '0;
            last_b  = '0;
            last_op = '0;
        end else begin
            sz = q.size();
            hv = (sz > 0) && (q[0].ready_edge <= edge_cnt);
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, hv});
            if (hv && rsp_valid) begin
                chk("rsp_result", rsp_result, q[0].result);
                chk("rsp_tag", {28'b0, rsp_tag}, {28'b0, q[0].tag});
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].err});
            end
            chk("inflight", {29'b0, inflight}, sz);
            chk("req_ready", {31'b0, req_ready}, {31'b0, sz < D});
            chk("alu_a", alu_a, last_a);
            chk("alu_b", alu_b, last_b);
            chk("alu_opcode", {29'b0, alu_opcode}, {29'b0, last_op});
            if (hv && rsp_ready) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (req_valid && sz < D) begin
                e.result     = model(req_a, req_b, req_op);
                e.tag        = req_tag;
                e.err        = (req_op > 3'd2);
                e.ready_edge = edge_cnt + 2;
                q.push_back(e);
                last_a  = req_a;
                last_b  = req_b;
                last_op = req_op;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic [TW-1:0] tag);
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_tag   = tag;
        req_valid = 1'b1;
        for (int k = 0; k < 50 && !req_ready; k++) begin
            @(posedge clk);
            #1;
        end
        if (!req_ready) timeout("send");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() != 0) timeout("drain");
    endtask

    vec_t vt[7];
    int   acc;
    int   pops0;
    bit   r;

    initial begin
        vt[0] = '{32'd5,          32'd7,          3'd0, 4'd3,  32'd12,         1'b0};
        vt[1] = '{32'd3,          32'd5,          3'd1, 4'd1,  32'hFFFF_FFFE,  1'b0};
        vt[2] = '{32'hFFFF_FFFF,  32'd1,          3'd2, 4'd2,  32'd1,          1'b0};
        vt[3] = '{32'd1,          32'd1,          3'd5, 4'd9,  32'd0,          1'b1};
        vt[4] = '{32'd1,          32'hFFFF_FFFF,  3'd2, 4'd4,  32'd0,          1'b0};
        vt[5] = '{32'h8000_0000,  32'd1,          3'd1, 4'd7,  32'h7FFF_FFFF,  1'b0};
        vt[6] = '{32'd0,          32'd0,          3'd7, 4'd15, 32'd0,          1'b1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        #1;
        chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset inflight", {29'b0, inflight}, 32'd0);
        chk("reset alu_a", alu_a, 32'd0);
        chk("reset rsp_result", rsp_result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset req_ready", {31'b0, req_ready}, 32'd1);

        // Single requests: opcode visible one edge after accept, response after two.
        rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(vt[i].a, vt[i].b, vt[i].op, vt[i].tag);
            chk("vec alu_opcode", {29'b0, alu_opcode}, {29'b0, vt[i].op});
            chk("vec early rsp_valid", {31'b0, rsp_valid}, 32'd0);
            @(posedge clk);
            #1;
            chk("vec rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("vec rsp_result", rsp_result, vt[i].exp_res);
            chk("vec rsp_tag", {28'b0, rsp_tag}, {28'b0, vt[i].tag});
            chk("vec rsp_err", {31'b0, rsp_err}, {31'b0, vt[i].exp_err});
        end
        drain();

        // Back-to-back SUB then LT.
        send(32'd3, 32'd5, 3'd1, 4'd1);
        send(32'hFFFF_FFFF, 32'd1, 3'd2, 4'd2);
        chk("b2b first result", rsp_result, 32'hFFFF_FFFE);
        chk("b2b first tag", {28'b0, rsp_tag}, 32'd1);
        @(posedge clk);
        #1;
        chk("b2b second result", rsp_result, 32'd1);
        chk("b2b second tag", {28'b0, rsp_tag}, 32'd2);
        chk("b2b second err", {31'b0, rsp_err}, 32'd0);
        drain();

        // Backpressure to full, then release and sustain one request per cycle.
        rsp_ready = 1'b0;
        pops0     = n_pop;
        acc       = 0;
        req_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_tag = 4'(acc);
            req_a   = 32'(acc * 3);
            req_b   = 32'd100;
            req_op  = 3'(acc % 3);
            r       = req_ready;
            @(posedge clk);
            #1;
            if (r) acc++;
        end
        chk("full accepted", acc, 32'd4);
        chk("full req_ready", {31'b0, req_ready}, 32'd0);
        chk("full inflight", {29'b0, inflight}, 32'd4);
        rsp_ready = 1'b1;
        chk("full before pop req_ready", {31'b0, req_ready}, 32'd0);
        for (int c = 0; c < 60 && acc < 24; c++) begin
            req_tag = 4'(acc);
            req_a   = 32'(acc * 3);
            req_b   = 32'd100;
            req_op  = 3'(acc % 3);
            r       = req_ready;
            @(posedge clk);
            #1;
            if (r) acc++;
            chk("sustained req_ready", {31'b0, req_ready}, 32'd1);
        end
        req_valid = 1'b0;
        if (acc < 24) timeout("sustained accepts");
        drain();
        chk("sustained pops", n_pop - pops0, 32'd24);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 1500; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            req_op    = 3'($urandom_range(0, 7));
            req_tag   = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       req_a = 32'h8000_0000;
                1:       req_a = 32'hFFFF_FFFF;
                default: req_a = $urandom;
            endcase
            req_b = ($urandom_range(0, 3) == 0) ? req_a : $urandom;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Reset with three entries in flight.
        rsp_ready = 1'b0;
        send(32'd1, 32'd2, 3'd0, 4'd1);
        send(32'd3, 32'd4, 3'd1, 4'd2);
        send(32'd5, 32'd6, 3'd2, 4'd3);
        chk("pre-reset inflight", {29'b0, inflight}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("async inflight", {29'b0, inflight}, 32'd0);
        chk("async alu_a", alu_a, 32'd0);
        chk("async alu_b", alu_b, 32'd0);
        chk("async alu_opcode", {29'b0, alu_opcode}, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        send(32'd10, 32'd20, 3'd0, 4'hA);
        @(posedge clk);
        #1;
        chk("post-reset rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("post-reset tag", {28'b0, rsp_tag}, 32'hA);
        chk("post-reset result", rsp_result, 32'd30);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
